// File: rtl/icache_fill_ctrl.sv
// Direct-mapped instruction cache with a word-by-word line-fill controller.
// Hits are answered combinationally. A miss stalls fetch while the line is
// refilled from backing memory over a req/ack handshake.
module icache_fill_ctrl #(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        FE_REQ,
  input  logic [63:0] FE_PC,
  input  logic        FLUSH,
  output logic [31:0] FE_INSTR,
  output logic        FE_HIT,
  output logic        IC_FE_MISS_STALL,
  output logic        MEM_REQ,
  output logic [63:0] MEM_ADDR,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA
);

  localparam int unsigned WW  = $clog2(WORDS);
  localparam int unsigned IW  = $clog2(LINES);
  localparam int unsigned OFF = 2 + WW;
  localparam int unsigned TW  = 64 - OFF - IW;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_VALIDATE
  } state_t;

  state_t            state_q, state_d;
  logic [WW-1:0]     cnt_q, cnt_d;
  logic [63:0]       line_base_q, line_base_d;
  logic              flush_pend_q, flush_pend_d;
  logic [LINES-1:0]  valid_q, valid_d;

  // Tag and data arrays are not reset; validity alone qualifies their contents.
  logic [TW-1:0]     tag_mem  [LINES];
  logic [31:0]       data_mem [LINES][WORDS];

  logic              aligned;
  logic [IW-1:0]     pc_idx;
  logic [TW-1:0]     pc_tag;
  logic [WW-1:0]     pc_word;
  logic [IW-1:0]     base_idx;
  logic [TW-1:0]     base_tag;
  logic              hit;
  logic              miss;
  logic              data_we;
  logic              tag_we;

  // Address decode and hit detection for the fetch PC and the latched line.
  always_comb begin
    aligned  = (FE_PC[1:0] == 2'b00);
    pc_idx   = FE_PC[OFF+IW-1:OFF];
    pc_tag   = FE_PC[63:OFF+IW];
    pc_word  = FE_PC[OFF-1:2];
    base_idx = line_base_q[OFF+IW-1:OFF];
    base_tag = line_base_q[63:OFF+IW];
    hit      = FE_REQ & aligned & (state_q == ST_IDLE) &
               valid_q[pc_idx] & (tag_mem[pc_idx] == pc_tag);
    miss     = FE_REQ & aligned & ~hit;
  end

  // State register and controller flops.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      line_base_q  <= '0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      line_base_q  <= line_base_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
    end
  end

  // Next-state logic: miss capture, word counting, validation and flush tracking.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    line_base_d  = line_base_q;
    flush_pend_d = flush_pend_q;
    valid_d      = valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (miss && !FLUSH) begin
          line_base_d = {FE_PC[63:OFF], {OFF{1'b0}}};
          cnt_d       = '0;
          state_d     = ST_FILL;
        end
      end
      ST_FILL: begin
        if (MEM_ACK) begin
          cnt_d = cnt_q + WW'(1);
          if (cnt_q == WW'(WORDS - 1)) begin
            state_d = ST_VALIDATE;
          end
        end
        if (FLUSH) begin
          flush_pend_d = 1'b1;
        end
      end
      ST_VALIDATE: begin
        valid_d[base_idx] = ~flush_pend_q;
        flush_pend_d      = 1'b0;
        state_d           = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // A flush landing in VALIDATE is absorbed here: the global clear overrides
    // the validate write, so no pending flag needs to survive into IDLE.
    if (FLUSH) begin
      valid_d = '0;
    end
  end

  // Output logic: fetch response, stall and memory request.
  always_comb begin
    FE_HIT           = hit;
    FE_INSTR         = hit ? data_mem[pc_idx][pc_word] : '0;
    IC_FE_MISS_STALL = (state_q != ST_IDLE) | miss;
    MEM_REQ          = (state_q == ST_FILL);
    MEM_ADDR         = (state_q == ST_FILL) ?
                       (line_base_q + {{(62-WW){1'b0}}, cnt_q, 2'b00}) : '0;
    data_we          = (state_q == ST_FILL) & MEM_ACK;
    tag_we           = (state_q == ST_VALIDATE);
  end

  // Line storage writes: data words as they return, tag at validation.
  always_ff @(posedge CLK) begin
    if (data_we) begin
      data_mem[base_idx][cnt_q] <= MEM_RDATA;
    end
    if (tag_we) begin
      tag_mem[base_idx] <= base_tag;
    end
  end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Self-checking bench for icache_fill_ctrl: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a line-level cache model.
module tb_icache_fill_ctrl;

  localparam int unsigned LINES      = 16;
  localparam int unsigned WORDS      = 4;
  localparam longint unsigned LBYTES = 4 * WORDS;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        FE_REQ;
  logic [63:0] FE_PC;
  logic        FLUSH;
  logic [31:0] FE_INSTR;
  logic        FE_HIT;
  logic        IC_FE_MISS_STALL;
  logic        MEM_REQ;
  logic [63:0] MEM_ADDR;
  logic        MEM_ACK;
  logic [31:0] MEM_RDATA;

  icache_fill_ctrl #(.LINES(LINES), .WORDS(WORDS)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .FE_REQ(FE_REQ), .FE_PC(FE_PC), .FLUSH(FLUSH),
    .FE_INSTR(FE_INSTR), .FE_HIT(FE_HIT), .IC_FE_MISS_STALL(IC_FE_MISS_STALL),
    .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Backing memory contents: word at address a.
  function automatic logic [31:0] mem_f(input logic [63:0] a);
    logic [63:0] w;
    w = a >> 2;
    return 32'h13 + w[31:0] - 32'd128;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: which lines hold which tags, plus the outstanding refill.
  bit          m_valid [LINES];
  logic [63:0] m_tag   [LINES];
  bit          m_fill, m_val, m_fpend, model_known;
  logic [63:0] m_base;
  int          m_k;

  bit          e_hit, e_stall, e_mreq;
  logic [31:0] e_instr;
  logic [63:0] e_addr;
  bit          o_hit, o_stall, o_mreq, first_hit;
  logic [31:0] o_instr;
  logic [63:0] o_addr;
  int          fill_cycles;

  function automatic int unsigned idx_of(input logic [63:0] a);
    return int'((a / LBYTES) % LINES);
  endfunction

  function automatic logic [63:0] tag_of(input logic [63:0] a);
    return a / (LBYTES * LINES);
  endfunction

  // One clock cycle: drive, predict, compare, advance the model across the edge.
  task automatic step(input bit req, input logic [63:0] pc, input bit flush,
                      input bit ack, input bit rst_n);
    bit idle, algn, was_fill;
    FE_REQ = req; FE_PC = pc; FLUSH = flush; MEM_ACK = ack; RESET_N = rst_n;
    idle    = !m_fill && !m_val;
    algn    = (pc % 4) == 0;
    e_hit   = req && algn && idle && m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    e_instr = e_hit ? mem_f(pc) : 32'h0;
    e_stall = !idle || (req && algn && !e_hit);
    e_mreq  = m_fill;
    e_addr  = m_fill ? m_base + 64'(4 * m_k) : 64'h0;
    MEM_RDATA = mem_f(e_addr);
    #3;
    o_hit = FE_HIT; o_instr = FE_INSTR; o_stall = IC_FE_MISS_STALL;
    o_mreq = MEM_REQ; o_addr = MEM_ADDR;
    if (MEM_REQ === 1'b1) fill_cycles++;
    if (model_known) begin
      chk("fe_hit", 64'(o_hit), 64'(e_hit));
      chk("fe_instr", 64'(o_instr), 64'(e_instr));
      chk("miss_stall", 64'(o_stall), 64'(e_stall));
      chk("mem_req", 64'(o_mreq), 64'(e_mreq));
      chk("mem_addr", o_addr, e_addr);
    end
    if (!rst_n) begin
      m_fill = 0; m_val = 0; m_fpend = 0; m_k = 0;
      for (int i = 0; i < int'(LINES); i++) m_valid[i] = 0;
      model_known = 1;
    end else begin
      was_fill = m_fill;
      if (m_fill) begin
        if (ack) begin
          m_k++;
          if (m_k == int'(WORDS)) begin m_fill = 0; m_val = 1; end
        end
      end else if (m_val) begin
        m_val = 0;
        if (!m_fpend) begin
          m_valid[idx_of(m_base)] = 1;
          m_tag[idx_of(m_base)]   = tag_of(m_base);
        end
        m_fpend = 0;
      end else if (req && algn && !e_hit && !flush) begin
        m_fill = 1; m_base = (pc / LBYTES) * LBYTES; m_k = 0;
      end
      if (flush) begin
        for (int i = 0; i < int'(LINES); i++) m_valid[i] = 0;
        if (was_fill) m_fpend = 1;
      end
    end
    @(posedge CLK); #1;
  endtask

  // Request pc and service the resulting refill; ack once every `period` fill cycles.
  task automatic fill_line(input logic [63:0] pc, input int unsigned period, input int flush_word);
    int unsigned ph, budget;
    bit a, f, was;
    ph = 0; budget = 0; fill_cycles = 0;
    step(1, pc, 0, 0, 1);
    first_hit = o_hit;
    while ((m_fill || m_val) && budget < 200) begin
      was = m_fill;
      a = m_fill && (ph == period - 1);
      f = m_fill && (flush_word >= 0) && (m_k == flush_word) && (ph == 0);
      step(1, pc, f, a, 1);
      if (was) ph = a ? 0 : ph + 1;
      budget++;
    end
    if (budget >= 200) begin
      checks++; errors++;
      $display("FAIL fill_timeout: got %0d cycles expected under 200", budget);
    end
  endtask

  typedef struct {
    bit          req;
    logic [63:0] pc;
    bit          hit;
    logic [31:0] instr;
    bit          stall;
    bit          mreq;
    logic [63:0] addr;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(input bit r, input logic [63:0] p, input bit h,
                              input logic [31:0] i, input bit s, input bit m,
                              input logic [63:0] a);
    vec_t v;
    v.req = r; v.pc = p; v.hit = h; v.instr = i; v.stall = s; v.mreq = m; v.addr = a;
    return v;
  endfunction

  logic [63:0] tags [4];

  initial begin
    // Cold miss of 512 with zero-wait memory, hit sweep, then a miss at 528.
    tbl[0]  = mk(1, 512, 0, 0,     1, 0, 0);
    tbl[1]  = mk(1, 512, 0, 0,     1, 1, 512);
    tbl[2]  = mk(1, 512, 0, 0,     1, 1, 516);
    tbl[3]  = mk(1, 512, 0, 0,     1, 1, 520);
    tbl[4]  = mk(1, 512, 0, 0,     1, 1, 524);
    tbl[5]  = mk(1, 512, 0, 0,     1, 0, 0);
    tbl[6]  = mk(1, 512, 1, 32'h13, 0, 0, 0);
    tbl[7]  = mk(1, 516, 1, 32'h14, 0, 0, 0);
    tbl[8]  = mk(1, 520, 1, 32'h15, 0, 0, 0);
    tbl[9]  = mk(1, 524, 1, 32'h16, 0, 0, 0);
    tbl[10] = mk(1, 528, 0, 0,     1, 0, 0);
    tbl[11] = mk(0, 0,   0, 0,     1, 1, 528);
    tbl[12] = mk(0, 0,   0, 0,     1, 1, 532);
    tbl[13] = mk(0, 0,   0, 0,     1, 1, 536);
    tbl[14] = mk(0, 0,   0, 0,     1, 1, 540);
    tbl[15] = mk(0, 0,   0, 0,     1, 0, 0);
    tbl[16] = mk(1, 514, 0, 0,     0, 0, 0);
    tbl[17] = mk(1, 532, 1, 32'h18, 0, 0, 0);

    model_known = 0; m_fill = 0; m_val = 0; m_fpend = 0; m_k = 0; m_base = 0;
    for (int i = 0; i < int'(LINES); i++) begin m_valid[i] = 0; m_tag[i] = 0; end
    RESET_N = 0; FE_REQ = 0; FE_PC = 0; FLUSH = 0; MEM_ACK = 0; MEM_RDATA = 0;
    @(posedge CLK); #1;

    // Reset state.
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1);
    chk("rst_hit", 64'(o_hit), 0);
    chk("rst_instr", 64'(o_instr), 0);
    chk("rst_memreq", 64'(o_mreq), 0);
    chk("rst_memaddr", o_addr, 0);
    chk("rst_stall_idle", 64'(o_stall), 0);

    // Vector table.
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].req, tbl[i].pc, 0, 1, 1);
      chk($sformatf("tbl%0d_hit", i), 64'(o_hit), 64'(tbl[i].hit));
      chk($sformatf("tbl%0d_instr", i), 64'(o_instr), 64'(tbl[i].instr));
      chk($sformatf("tbl%0d_stall", i), 64'(o_stall), 64'(tbl[i].stall));
      chk($sformatf("tbl%0d_mreq", i), 64'(o_mreq), 64'(tbl[i].mreq));
      chk($sformatf("tbl%0d_addr", i), o_addr, tbl[i].addr);
    end

    // Conflict: 768 evicts 512, then 512 misses again.
    fill_line(768, 1, -1);
    chk("conf768_miss", 64'(first_hit), 0);
    chk("conf768_cycles", 64'(fill_cycles), 64'(WORDS));
    step(1, 768, 0, 0, 1);
    chk("conf768_hit", 64'(o_hit), 1);
    chk("conf768_instr", 64'(o_instr), 64'h53);
    fill_line(512, 1, -1);
    chk("conf512_miss", 64'(first_hit), 0);
    step(1, 512, 0, 0, 1);
    chk("conf512_hit", 64'(o_hit), 1);

    // Wait states: ack every third cycle.
    fill_line(64'h10040, 3, -1);
    chk("wait_fill_cycles", 64'(fill_cycles), 64'(3 * WORDS));
    step(1, 64'h10048, 0, 0, 1);
    chk("wait_hit", 64'(o_hit), 1);
    chk("wait_instr", 64'(o_instr), 64'(mem_f(64'h10048)));

    // Flush during the second word: fill completes but the line stays invalid.
    fill_line(768, 1, 1);
    chk("flushfill_cycles", 64'(fill_cycles), 64'(WORDS));
    step(1, 768, 0, 0, 1);
    chk("flushfill_miss", 64'(o_hit), 0);
    chk("flushfill_stall", 64'(o_stall), 1);
    fill_line(768, 1, -1);
    step(1, 768, 0, 0, 1);
    chk("refill_hit", 64'(o_hit), 1);
    // Flush in idle.
    step(0, 0, 1, 0, 1);
    step(1, 768, 0, 0, 1);
    chk("idleflush_miss", 64'(o_hit), 0);
    fill_line(768, 1, -1);

    // Reset during a fill.
    step(1, 64'h3080, 0, 0, 1);
    step(1, 64'h3080, 0, 1, 1);
    step(1, 64'h3080, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    chk("rstfill_memreq", 64'(o_mreq), 0);
    step(1, 64'h3080, 0, 0, 1);
    chk("rstfill_miss", 64'(o_hit), 0);
    chk("rstfill_stall", 64'(o_stall), 1);
    fill_line(64'h3080, 1, -1);

    // Misaligned PC.
    step(1, 514, 0, 0, 1);
    chk("misal_hit", 64'(o_hit), 0);
    chk("misal_stall", 64'(o_stall), 0);
    chk("misal_memreq", 64'(o_mreq), 0);

    // Randomized traffic.
    tags[0] = 64'h2; tags[1] = 64'h3; tags[2] = 64'h12340; tags[3] = 64'hFF_FFFF_FFFF_FFFF;
    for (int n = 0; n < 3000; n++) begin
      logic [63:0] pc;
      pc = tags[$urandom_range(3)] * (LBYTES * LINES)
         + 64'($urandom_range(3)) * LBYTES
         + 64'($urandom_range(WORDS - 1)) * 4;
      if ($urandom_range(19) == 0) pc = pc + 64'($urandom_range(3, 1));
      step($urandom_range(3) != 0, pc, $urandom_range(39) == 0,
           $urandom_range(9) < 6, $urandom_range(299) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_fill_ctrl.md
# icache_fill_ctrl

Direct-mapped instruction cache with a line-fill controller: the responder side of the fetch stage's instruction lookup. It answers the fetch stage's PC in the same cycle on a hit. On a miss it stalls fetch, refills the line word-by-word from backing memory over a req/ack handshake, and then releases the stall. It sits between the fetch stage (upstream) and the unified memory/bus port (downstream). The fetch stage ORs `IC_FE_MISS_STALL` into its existing PC/latch stall terms.

## Interface
Parameters:
- `LINES`, 16: number of cache lines; power of two, ≥2.
- `WORDS`, 4: 32-bit instruction words per line; power of two, ≥2.

Ports:
- `CLK`  in  1  sole clock; all state updates on the rising edge.
- `RESET_N`  in  1  reset, synchronous, active-low.
- `FE_REQ`  in  1  fetch requests a lookup this cycle.
- `FE_PC`  in  64  fetch address.
- `FLUSH`  in  1  invalidate all lines (fence.i / context switch); one-cycle pulse.
- `FE_INSTR`  out  32  instruction word; 0 when `FE_HIT`=0.
- `FE_HIT`  out  1  `FE_INSTR` is valid this cycle.
- `IC_FE_MISS_STALL`  out  1  fetch must hold PC and not latch DE.
- `MEM_REQ`  out  1  word read request to backing memory.
- `MEM_ADDR`  out  64  word address of the request; 0 when `MEM_REQ`=0.
- `MEM_ACK`  in  1  memory returns `MEM_RDATA` for `MEM_ADDR` this cycle.
- `MEM_RDATA`  in  32  read data, valid with `MEM_ACK`.

## Operation
- Address split: OFF = 2+log2(WORDS) bits; IDX = PC[OFF+log2(LINES)-1 : OFF]; TAG = PC[63 : OFF+log2(LINES)]; word select = PC[OFF-1:2]. Defaults: OFF=4, IDX=PC[7:4], TAG=PC[63:8].
- Storage: valid[LINES], tag[LINES], data[LINES][WORDS]. Only valid bits are reset.
- hit = FE_REQ & aligned & state==IDLE & valid[IDX] & tag[IDX]==TAG. aligned = (PC[1:0]==0).
- Misaligned PC: FE_HIT=0, no stall, no fill. Fetch raises IAM itself.
- FSM states:
  - IDLE: on FE_REQ & aligned & !hit & !FLUSH, latch line_base = PC with low OFF bits zeroed, cnt←0, go to FILL.
  - FILL: MEM_REQ=1, MEM_ADDR=line_base+(cnt<<2).
    - MEM_REQ stays high and MEM_ADDR stable until MEM_ACK.
    - On each MEM_ACK, data[idx(line_base)][cnt]←MEM_RDATA and cnt++.
    - The ack with cnt==WORDS-1 moves to VALIDATE.
  - VALIDATE: tag←TAG(line_base); valid←!flush_pend; flush_pend←0; go to IDLE.
- IC_FE_MISS_STALL = (state!=IDLE) | (FE_REQ & aligned & !hit).
- FLUSH:
  - Clears all valid bits on the next edge, in any state.
  - If it arrives in FILL or VALIDATE, set flush_pend. The fill completes on the bus (no abandoned handshake) but the line is not validated.
  - FLUSH in IDLE together with a miss: flush only; the miss is re-detected next cycle.
- FE_PC change during a fill (redirect): the fill continues for the latched line. The new PC is looked up on return to IDLE.

## Timing
- Reset (RESET_N=0 at an edge): state=IDLE, cnt=0, flush_pend=0, all valid=0.
  - Outputs after reset: FE_HIT=0, FE_INSTR=0, MEM_REQ=0, MEM_ADDR=0.
  - IC_FE_MISS_STALL=0 unless FE_REQ with an aligned PC.
- Hit: combinational, zero added latency. Fetch latches FE_INSTR at the same edge.
- Miss with zero-wait memory (MEM_ACK in the cycle MEM_REQ rises), detected in cycle N:
  - Cycles N+1..N+WORDS: FILL.
  - Cycle N+WORDS+1: VALIDATE.
  - Cycle N+WORDS+2: IDLE, hit, stall=0.
  - Penalty = WORDS+2 cycles (6 by default).
- Each memory wait cycle adds one cycle.
- Reset mid-fill: MEM_REQ drops at the reset edge, and the partial line stays invalid. Memory is reset by the same RESET_N.
- MEM_ACK while not in FILL is ignored.

## Test plan
- Cold miss: reset, FE_REQ=1, PC=512, memory returns 0x00000013+i each cycle. MEM_ADDR must be 512,516,520,524 in successive cycles, stall high 6 cycles, then FE_HIT=1, FE_INSTR=0x00000013.
- Hit sweep: after the cold miss, PC=516/520/524 each hit in the same cycle with no stall and return the matching words; PC=528 misses.
- Conflict: fill 512, then PC=768 (same IDX, different TAG) misses and refills; PC=512 then misses again.
- Wait states: MEM_ACK only every 3rd cycle. MEM_ADDR must hold stable between acks, the fill takes 12 FILL cycles, and FE_INSTR must be correct afterwards.
- Flush: FLUSH during the 2nd FILL word. The fill must complete 4 words, then PC=512 still misses. FLUSH in IDLE must make a previously hitting PC miss.
- Reset/misaligned:
  - RESET_N=0 during FILL: MEM_REQ=0 next cycle, and the line misses after reset.
  - PC=514: FE_HIT=0, stall=0, MEM_REQ=0.
